// File: rtl/exception_unit.sv
// Trap and mret sequencer at the commit stage. It takes one event from the commit
// stage, writes mepc/mcause/mtval through a one-cycle CSR pulse, and then redirects
// the PC. stall and flush cover the whole sequence.
module exception_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_wb,
  input  logic [31:0] pc_wb,
  input  logic [31:0] inst_wb,
  input  logic        illegal_inst,
  input  logic        ecall,
  input  logic        l_fault,
  input  logic        s_fault,
  input  logic        mret,
  input  logic [31:0] mem_addr,
  input  logic        ext_int,
  input  logic [31:0] mstatus,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc_i,
  input  logic [31:0] mcause_i,
  input  logic [31:0] mtval_i,
  output logic        is_trap,
  output logic        is_mret,
  output logic [31:0] mepc,
  output logic [31:0] mcause,
  output logic [31:0] mtval,
  output logic        flush,
  output logic        stall,
  output logic        redirect,
  output logic [31:0] redirect_pc
);

  typedef enum logic [1:0] {StIdle, StWrite, StJump} state_e;

  state_e      state_q;
  logic        int_pending_q;
  logic        take_int_q;   // accepted event was an interrupt (selects vectored target)
  logic        take_mret_q;  // accepted event was an mret (target comes from mepc_i)

  logic        any_exc;
  logic        can_accept;
  logic        accept_trap;
  logic        accept_int;
  logic        accept_mret;
  logic [31:0] cause_d;
  logic [31:0] tval_d;
  logic [31:0] trap_base;
  logic [31:0] jump_target;

  assign any_exc     = illegal_inst | ecall | l_fault | s_fault;
  assign can_accept  = (state_q == StIdle) & valid_wb;
  assign accept_int  = can_accept & int_pending_q;
  assign accept_trap = can_accept & (int_pending_q | any_exc);
  // mret only wins when nothing else is present in the same cycle
  assign accept_mret = can_accept & mret & ~int_pending_q & ~any_exc;

  // Cause and trap value for the highest-priority trap source
  always_comb begin
    cause_d = 32'd7;
    tval_d  = mem_addr;
    if (int_pending_q) begin
      cause_d = 32'h8000_000B;
      tval_d  = 32'd0;
    end else if (illegal_inst) begin
      cause_d = 32'd2;
      tval_d  = inst_wb;
    end else if (ecall) begin
      cause_d = 32'd11;
      tval_d  = 32'd0;
    end else if (l_fault) begin
      cause_d = 32'd5;
      tval_d  = mem_addr;
    end
  end

  // Redirect target, evaluated on the WRITE->JUMP transition
  always_comb begin
    trap_base = {mtvec[31:2], 2'b00};
    if (take_mret_q) begin
      jump_target = {mepc_i[31:2], 2'b00};
    end else if (take_int_q && (mtvec[1:0] == 2'b01)) begin
      jump_target = trap_base + 32'd44;
    end else begin
      jump_target = trap_base;
    end
  end

  // Level interrupt latch, qualified by mstatus.MIE
  always_ff @(posedge clk) begin
    if (rst) begin
      int_pending_q <= 1'b0;
    end else if (accept_int || !ext_int) begin
      int_pending_q <= 1'b0;
    end else if (mstatus[3]) begin
      int_pending_q <= 1'b1;
    end
  end

  // Sequencer FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      take_int_q  <= 1'b0;
      take_mret_q <= 1'b0;
      is_trap     <= 1'b0;
      is_mret     <= 1'b0;
      mepc        <= 32'd0;
      mcause      <= 32'd0;
      mtval       <= 32'd0;
      flush       <= 1'b0;
      stall       <= 1'b0;
      redirect    <= 1'b0;
      redirect_pc <= 32'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept_trap || accept_mret) begin
            state_q     <= StWrite;
            take_int_q  <= accept_int;
            take_mret_q <= accept_mret;
            is_trap     <= accept_trap;
            is_mret     <= accept_mret;
            mepc        <= accept_mret ? mepc_i   : pc_wb;
            mcause      <= accept_mret ? mcause_i : cause_d;
            mtval       <= accept_mret ? mtval_i  : tval_d;
            flush       <= 1'b1;
            stall       <= 1'b1;
          end
        end
        StWrite: begin
          state_q     <= StJump;
          is_trap     <= 1'b0;
          is_mret     <= 1'b0;
          redirect    <= 1'b1;
          redirect_pc <= jump_target;
        end
        StJump: begin
          state_q     <= StIdle;
          redirect    <= 1'b0;
          redirect_pc <= 32'd0;
          flush       <= 1'b0;
          stall       <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/exception_unit.md
EXCEPTION_UNIT -- requirements
Module: exception_unit

Interface
REQ-001 The block SHALL expose these ports, clock and reset first; the single clock is clk, and rst is a synchronous, active-high reset:
  clk  in  1  clock
  rst  in  1  synchronous active-high reset
  valid_wb  in  1  commit-stage instruction valid
  pc_wb  in  32  commit-stage PC
  inst_wb  in  32  commit-stage instruction word
  illegal_inst  in  1  illegal-instruction flag
  ecall  in  1  ecall flag
  l_fault  in  1  load access fault
  s_fault  in  1  store access fault
  mret  in  1  mret at commit
  mem_addr  in  32  faulting data address
  ext_int  in  1  external interrupt, level
  mstatus  in  32  current mstatus (bit 3 MIE)
  mtvec  in  32  current mtvec
  mepc_i  in  32  current mepc
  mcause_i  in  32  current mcause
  mtval_i  in  32  current mtval
  is_trap  out  1  trap-entry pulse to the CSR file
  is_mret  out  1  mret pulse to the CSR file
  mepc  out  32  mepc value to write
  mcause  out  32  mcause value to write
  mtval  out  32  mtval value to write
  flush  out  1  kill younger pipeline stages
  stall  out  1  freeze the front end
  redirect  out  1  PC redirect valid
  redirect_pc  out  32  redirect target

Function
REQ-002 The FSM SHALL have three states: IDLE, WRITE and JUMP; transitions are IDLE->WRITE on an accepted event, WRITE->JUMP always, and JUMP->IDLE always.
REQ-003 An event SHALL be accepted only in IDLE with valid_wb=1; inputs arriving in WRITE or JUMP SHALL be ignored.
REQ-004 The block SHALL set int_pending when ext_int=1 and mstatus[3]=1, and clear it on interrupt entry or when ext_int=0.
REQ-005 Event priority, highest first: interrupt (mcause 0x8000000B); illegal_inst (2); ecall (11); l_fault (5); s_fault (7); mret.
REQ-006 mret SHALL be accepted only if no other event is present in the same cycle.
REQ-007 On trap acceptance, the block SHALL register mepc=pc_wb and mcause per REQ-005; mtval SHALL be inst_wb for illegal_inst, mem_addr for l_fault/s_fault, and 0 otherwise.
REQ-008 On mret acceptance, the block SHALL register mepc=mepc_i, mcause=mcause_i and mtval=mtval_i, so that the CSR writes leave these values unchanged.
REQ-009 In WRITE, exactly one of is_trap or is_mret SHALL be high, for exactly one cycle.
REQ-010 stall and flush SHALL be high in both WRITE and JUMP, and low in IDLE.
REQ-011 In JUMP, redirect SHALL be high for one cycle.
REQ-012 Trap target: {mtvec[31:2],2'b00} when mtvec[1:0]=0 or for any exception; {mtvec[31:2],2'b00}+44 for an interrupt when mtvec[1:0]=1.
REQ-013 mret target SHALL be mepc_i as sampled in JUMP, with bits [1:0] forced to 0.
REQ-014 Accept-to-redirect latency SHALL be 2 cycles.
REQ-015 The block SHALL accept a new event no earlier than the cycle after JUMP.
REQ-016 mepc, mcause and mtval SHALL hold their values outside WRITE.
REQ-017 An interrupt with valid_wb=0 SHALL remain pending until the next valid_wb.

Reset
REQ-018 rst=1 at a clock edge SHALL force IDLE and clear int_pending, regardless of the current state.
REQ-019 rst=1 at a clock edge SHALL drive every output to 0, including a reset that aborts WRITE or JUMP.
REQ-020 After reset, no is_trap, is_mret or redirect pulse SHALL appear without a new accepted event.

Verification
REQ-021 illegal_inst, pc_wb=0x100, inst_wb=0xFFFFFFFF, mtvec=0x200 -> cycle+1: is_trap=1, mepc=0x100, mcause=2, mtval=0xFFFFFFFF; cycle+2: redirect_pc=0x200.
REQ-022 ext_int=1, MIE=1, mtvec=0x201, together with ecall at pc_wb=0x40 -> mcause=0x8000000B, mepc=0x40, redirect_pc=0x22C; ecall is dropped.
REQ-023 mret, mepc_i=0x1234, mcause_i=11 -> is_mret=1, mepc=0x1234, mcause=11; next cycle redirect_pc=0x1234.
REQ-024 l_fault, mem_addr=0xDEAD0000 -> mcause=5, mtval=0xDEAD0000; an ecall in the WRITE cycle produces no second trap.
REQ-025 rst asserted during WRITE -> next cycle IDLE, all outputs 0, no redirect.
REQ-026 ext_int=1 with MIE=0 -> no trap; then MIE=1 with valid_wb=1 -> trap taken 1 cycle after pending sets.
